accel_rate_ticker: RTL and testbench

Converts the accelerometer X/Y samples into directional movement ticks for the ball logic, with tick rate proportional to tilt magnitude. It replaces the single-threshold ticker with configurable sample width, zero point, dead zone, up to LEVELS speed levels and optional hysteresis. It sits between the accelerometer controller and the ball's `movement` input.

---
 rtl/accel_rate_ticker.sv | 179 +++++++++++++++++
 tb/tb_accel_rate_ticker.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/accel_rate_ticker.sv
// accel_rate_ticker: converts accelerometer X/Y samples into directional
// movement ticks whose rate scales with tilt magnitude.
//
// Optional build macro: ACCEL_TICK_HYST_EN
//   defined   -> a level falls only once mag drops HYST below its entry
//                threshold
//   undefined -> the level is the plain threshold function of mag
//
// Each axis is an independent two-stage pipeline (sample, level) followed by
// a period counter FSM:
//
//   state | meaning
//   ------+------------------------------------------------------------
//   IDLE  | level 0 or enable low; counter held at 0, no ticks
//   RUN   | level >= 1 and enable high; counter advances, tick on period
//
// Axis index 0 is X (positive = right), index 1 is Y (positive = down).
// ticks = {right, left, down, up}.

module accel_rate_ticker #(
   parameter int ACCEL_W   = 9,
   parameter int ZERO      = 256,
   parameter int DEAD      = 16,
   parameter int STEP_LOG2 = 5,
   parameter int LEVELS    = 4,
   parameter int CLK_HZ    = 100000000,
   parameter int BASE_HZ   = 30,
   parameter int HYST      = 4
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               enable,
   input  logic [ACCEL_W-1:0] accel_x_in,
   input  logic [ACCEL_W-1:0] accel_y_in,
   output logic [3:0]         ticks,
   output logic [3:0]         x_level,
   output logic [3:0]         y_level
);

   localparam logic [0:0]         ST_IDLE     = 1'b0;
   localparam logic [0:0]         ST_RUN      = 1'b1;
   localparam int                 STEP        = 1 << STEP_LOG2;
   localparam logic [31:0]        BASE_PERIOD = 32'(CLK_HZ / BASE_HZ);
   localparam logic [ACCEL_W-1:0] ZERO_V      = ACCEL_W'(ZERO);

`ifdef ACCEL_TICK_HYST_EN
   localparam int HYST_EFF = HYST;
`else
   // Zero margin makes the falling threshold coincide with the rising one,
   // so the shared next-level rule collapses to the plain threshold function.
   localparam int HYST_EFF = HYST * 0;
`endif

   logic [ACCEL_W-1:0] smp_d   [2];
   logic [ACCEL_W-1:0] smp_q   [2];
   logic [ACCEL_W-1:0] mag     [2];
   logic               sgn_d   [2];
   logic               sgn_q   [2];
   logic [3:0]         lvl_d   [2];
   logic [3:0]         lvl_q   [2];
   logic               dir_d   [2];
   logic               dir_q   [2];
   logic [0:0]         st_d    [2];
   logic [0:0]         st_q    [2];
   logic [31:0]        cnt_d   [2];
   logic [31:0]        cnt_q   [2];
   logic [31:0]        cnt_eff [2];
   logic [31:0]        per     [2];
   logic               run     [2];
   logic               flip    [2];
   logic [1:0]         tick_d  [2];
   logic [1:0]         tick_q  [2];

   // Level from magnitude alone: dead zone, then one level per STEP, clamped.
   function automatic logic [3:0] plain_level(input logic [ACCEL_W-1:0] m);
      int mi;
      int lv;
      mi = int'(m);
      if (mi < DEAD) return 4'd0;
      lv = 1 + ((mi - DEAD) >> STEP_LOG2);
      if (lv > LEVELS) lv = LEVELS;
      return 4'(lv);
   endfunction

   // Rising follows the plain rule; falling from cur waits until mag is
   // HYST_EFF below the entry threshold of cur, then lands on the plain level.
   function automatic logic [3:0] next_level(input logic [ACCEL_W-1:0] m,
                                             input logic [3:0]         cur);
      logic [3:0] pl;
      int         thr;
      pl  = plain_level(m);
      thr = DEAD + (int'(cur) - 1) * STEP - HYST_EFF;
      if ((pl < cur) && (int'(m) >= thr)) return cur;
      return pl;
   endfunction

   // Tick period for a level: base period halved per level above 1, never 0.
   function automatic logic [31:0] period_of(input logic [3:0] lvl);
      logic [31:0] p;
      if (lvl == 4'd0) p = BASE_PERIOD;
      else             p = BASE_PERIOD >> (lvl - 4'd1);
      if (p == 32'd0) p = 32'd1;
      return p;
   endfunction

   // Stage 1: capture raw samples.
   always_comb begin
      smp_d[0] = accel_x_in;
      smp_d[1] = accel_y_in;
   end

   // Stage 2: sign, magnitude about ZERO, and speed level.
   always_comb begin
      for (int a = 0; a < 2; a++) begin
         sgn_d[a] = 1'b0;
         mag[a]   = '0;
         if (smp_q[a] > ZERO_V) begin
            sgn_d[a] = 1'b1;
            mag[a]   = smp_q[a] - ZERO_V;
         end else begin
            mag[a]   = ZERO_V - smp_q[a];
         end
         lvl_d[a] = next_level(mag[a], lvl_q[a]);
      end
   end

   // Period counter FSM: count up in RUN, tick and wrap at period-1.
   always_comb begin
      for (int a = 0; a < 2; a++) begin
         run[a]     = (lvl_q[a] != 4'd0) && enable;
         flip[a]    = (st_q[a] == ST_RUN) && (sgn_q[a] != dir_q[a]);
         per[a]     = period_of(lvl_q[a]);
         // A sign flip restarts the period so the old direction never fires.
         cnt_eff[a] = flip[a] ? 32'd0 : cnt_q[a];
         dir_d[a]   = sgn_q[a];
         st_d[a]    = ST_IDLE;
         cnt_d[a]   = 32'd0;
         tick_d[a]  = 2'b00;
         if (run[a]) begin
            st_d[a] = ST_RUN;
            // >= rather than == so a faster level applies at once.
            if (cnt_eff[a] >= per[a] - 32'd1) begin
               cnt_d[a]  = 32'd0;
               tick_d[a] = sgn_q[a] ? 2'b10 : 2'b01;
            end else begin
               cnt_d[a]  = cnt_eff[a] + 32'd1;
            end
         end
      end
   end

   // State registers with synchronous active-low reset.
   always_ff @(posedge clk) begin
      for (int a = 0; a < 2; a++) begin
         if (!reset) begin
            smp_q[a]  <= ZERO_V;
            sgn_q[a]  <= 1'b0;
            lvl_q[a]  <= 4'd0;
            dir_q[a]  <= 1'b0;
            st_q[a]   <= ST_IDLE;
            cnt_q[a]  <= 32'd0;
            tick_q[a] <= 2'b00;
         end else begin
            smp_q[a]  <= smp_d[a];
            sgn_q[a]  <= sgn_d[a];
            lvl_q[a]  <= lvl_d[a];
            dir_q[a]  <= dir_d[a];
            st_q[a]   <= st_d[a];
            cnt_q[a]  <= cnt_d[a];
            tick_q[a] <= tick_d[a];
         end
      end
   end

   assign ticks   = {tick_q[0], tick_q[1]};
   assign x_level = lvl_q[0];
   assign y_level = lvl_q[1];

endmodule

// File: tb/tb_accel_rate_ticker.sv
// Bench for accel_rate_ticker with CLK_HZ=1000, BASE_HZ=10 (periods 100/50/25/12).
// Reference model tracks, per axis, the cycle at which the current period
// started and expects a tick once a full period has elapsed since then.

module tb_accel_rate_ticker;

   localparam int ZERO    = 256;
   localparam int DEAD    = 16;
   localparam int STEP    = 32;
   localparam int LEVELS  = 4;
   localparam int CLK_HZ  = 1000;
   localparam int BASE_HZ = 10;
   localparam int HYST    = 4;

   logic       clk    = 1'b0;
   logic       reset  = 1'b0;
   logic       enable = 1'b1;
   logic [8:0] ax     = 9'd256;
   logic [8:0] ay     = 9'd256;
   logic [3:0] ticks;
   logic [3:0] x_level;
   logic [3:0] y_level;

   int checks = 0;
   int errors = 0;
   int cyc    = 0;

   int         m_s1     [2];
   int         m_lvl    [2];
   int         m_sgn    [2];
   int         m_prev   [2];
   int         m_anchor [2];
   logic [3:0] m_ticks;

   always #5 clk = ~clk;

   accel_rate_ticker #(
      .CLK_HZ (CLK_HZ),
      .BASE_HZ(BASE_HZ)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .enable    (enable),
      .accel_x_in(ax),
      .accel_y_in(ay),
      .ticks     (ticks),
      .x_level   (x_level),
      .y_level   (y_level)
   );

   function automatic int mdl_plain(int mag);
      int lv;
      if (mag < DEAD) return 0;
      lv = 1 + (mag - DEAD) / STEP;
      return (lv > LEVELS) ? LEVELS : lv;
   endfunction

   function automatic int mdl_next(int mag, int cur);
      int pl;
      pl = mdl_plain(mag);
`ifdef ACCEL_TICK_HYST_EN
      if (pl < cur && mag >= DEAD + (cur - 1) * STEP - HYST) return cur;
`endif
      return pl;
   endfunction

   function automatic int mdl_period(int k);
      int p;
      p = (CLK_HZ / BASE_HZ) / (1 << (k - 1));
      return (p < 1) ? 1 : p;
   endfunction

   // Advance the model by one clock edge using the inputs seen at that edge.
   task automatic model_edge();
      logic [3:0] t;
      int         mag;
      t = 4'b0000;
      for (int a = 0; a < 2; a++) begin
         if (!reset) begin
            m_s1[a]     = ZERO;
            m_lvl[a]    = 0;
            m_sgn[a]    = 0;
            m_prev[a]   = 0;
            m_anchor[a] = cyc;
         end else begin
            if (m_sgn[a] != m_prev[a]) m_anchor[a] = cyc - 1;
            if (m_lvl[a] != 0 && enable) begin
               if (cyc - m_anchor[a] >= mdl_period(m_lvl[a])) begin
                  if (a == 0) t[m_sgn[a] ? 3 : 2] = 1'b1;
                  else        t[m_sgn[a] ? 1 : 0] = 1'b1;
                  m_anchor[a] = cyc;
               end
            end else begin
               m_anchor[a] = cyc;
            end
            m_prev[a] = m_sgn[a];
            mag       = (m_s1[a] > ZERO) ? m_s1[a] - ZERO : ZERO - m_s1[a];
            m_sgn[a]  = (m_s1[a] > ZERO) ? 1 : 0;
            m_lvl[a]  = mdl_next(mag, m_lvl[a]);
            m_s1[a]   = (a == 0) ? int'(ax) : int'(ay);
         end
      end
      m_ticks = t;
   endtask

   task automatic step();
      @(posedge clk);
      cyc++;
      model_edge();
      #1;
      checks++;
      assert (ticks === m_ticks) else begin
         errors++;
         $error("FAIL ticks cyc=%0d got %b exp %b", cyc, ticks, m_ticks);
      end
      checks++;
      assert (x_level === 4'(m_lvl[0])) else begin
         errors++;
         $error("FAIL x_level cyc=%0d got %0d exp %0d", cyc, x_level, m_lvl[0]);
      end
      checks++;
      assert (y_level === 4'(m_lvl[1])) else begin
         errors++;
         $error("FAIL y_level cyc=%0d got %0d exp %0d", cyc, y_level, m_lvl[1]);
      end
   endtask

   task automatic run(input int n);
      repeat (n) step();
   endtask

   function automatic logic [8:0] pick_sample();
      int v;
      if ($urandom_range(0, 3) == 0) v = int'($urandom_range(0, 511));
      else                           v = ZERO - 60 + int'($urandom_range(0, 120));
      return 9'(v);
   endfunction

   initial begin
      int c0;
      int t0;
      int k;
      int exp_hold;
      for (int a = 0; a < 2; a++) begin
         m_s1[a] = ZERO; m_lvl[a] = 0; m_sgn[a] = 0; m_prev[a] = 0; m_anchor[a] = 0;
      end
      m_ticks = 4'b0000;

      // Reset held with extreme tilts on both axes.
      reset = 1'b0; ax = 9'd511; ay = 9'd0;
      run(5);
      reset = 1'b1;
      run(1);

      // Dead zone edge: mag 15.
      ax = 9'd271; ay = 9'd256;
      run(1000);

      // Level 1 right: latency and first-tick spacing.
      ax = 9'd272;
      c0 = cyc;
      k  = 0;
      while (x_level != 4'd1 && k < 10) begin step(); k++; end
      t0 = cyc;
      checks++;
      assert (t0 - c0 == 2) else begin
         errors++;
         $error("FAIL level_latency got %0d exp 2", t0 - c0);
      end
      k = 0;
      while (!ticks[3] && k < 200) begin step(); k++; end
      checks++;
      assert (cyc - t0 == 100) else begin
         errors++;
         $error("FAIL first_tick_l1 got %0d exp 100", cyc - t0);
      end
      run(250);

      // Saturation left, enable dropped mid-period then restored.
      ax = 9'd0;
      run(60);
      enable = 1'b0;
      run(20);
      enable = 1'b1;
      c0 = cyc;
      k  = 0;
      while (!ticks[2] && k < 40) begin step(); k++; end
      checks++;
      assert (cyc - c0 == 12) else begin
         errors++;
         $error("FAIL reenable_tick got %0d exp 12", cyc - c0);
      end
      run(40);

      // Direction flip on Y at level 2, mid-period.
      ax = 9'd256; ay = 9'd304;
      run(120);
      ay = 9'd208;
      c0 = cyc;
      k  = 0;
      while (!ticks[0] && k < 100) begin step(); k++; end
      checks++;
      assert (cyc - c0 == 52) else begin
         errors++;
         $error("FAIL flip_first_tick got %0d exp 52", cyc - c0);
      end
      run(60);

      // Hysteresis around the level-2 threshold.
      ay = 9'd304;
      run(60);
      ay = 9'd302;
      run(4);
`ifdef ACCEL_TICK_HYST_EN
      exp_hold = 2;
`else
      exp_hold = 1;
`endif
      checks++;
      assert (y_level === 4'(exp_hold)) else begin
         errors++;
         $error("FAIL hyst_mag46 got %0d exp %0d", y_level, exp_hold);
      end
      ay = 9'd299;
      run(4);
      checks++;
      assert (y_level === 4'd1) else begin
         errors++;
         $error("FAIL hyst_mag43 got %0d exp 1", y_level);
      end
      run(120);

      // Randomized phase: tilt changes, enable toggles, mid-period resets.
      for (int n = 0; n < 40; n++) begin
         k  = int'($urandom_range(0, 9));
         ax = pick_sample();
         ay = pick_sample();
         if (k == 0) enable = ~enable;
         if (k == 1) begin
            reset = 1'b0;
            run(2);
            reset = 1'b1;
         end
         run(int'($urandom_range(1, 150)));
      end
      enable = 1'b1;
      ax = 9'd0; ay = 9'd511;
      run(100);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
